// File: rtl/instr_prefetch_queue.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : instr_prefetch_queue                                        |
// | Description : In-order instruction prefetch queue. Issues sequential      |
// |               word fetches ahead of the core and buffers up to DEPTH      |
// |               returned instructions tagged with their addresses. In-      |
// |               flight fetches are discarded when the core redirects.       |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
// | Parameters : DEPTH     queue entries (power of two, 2..16)                |
// |              RESET_PC  first fetch address after reset                    |
// | Ports      : CLK         clock, rising edge                                |
// |              Reset       synchronous active-low reset                      |
// |              IMemReq     fetch request valid                               |
// |              IMemAddr    fetch word address                                |
// |              IMemGnt     memory accepts the request this cycle             |
// |              IMemRValid  response valid (in request order)                 |
// |              IMemRData   response instruction word                         |
// |              Instr       head instruction (0 when not valid)               |
// |              InstrPC     address of Instr (0 when not valid)               |
// |              InstrValid  head entry valid                                  |
// |              Take        core consumes the head this cycle                 |
// |              Redirect    flush and restart fetch at RedirectPC             |
// |              RedirectPC  new fetch address, bits [1:0] ignored             |
// | Build option: PREFETCH_BYPASS_EN - present a response arriving into an    |
// |               empty queue combinationally in the same cycle.              |
// +--------------------------------------------------------------------------+
module instr_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemGnt,
    input  logic        IMemRValid,
    input  logic [31:0] IMemRData,
    output logic [31:0] Instr,
    output logic [31:0] InstrPC,
    output logic        InstrValid,
    input  logic        Take,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC
);

    localparam int                 c_PTR_W   = $clog2(DEPTH);
    localparam int                 c_CNT_W   = c_PTR_W + 1;
    localparam int                 c_SUM_W   = c_CNT_W + 2;
    localparam logic [c_SUM_W-1:0] c_DEPTH_S = c_SUM_W'(DEPTH);
    localparam logic [31:0]        c_ALIGN   = 32'hFFFF_FFFC;

    logic [31:0]        r_fifo_pc   [DEPTH];
    logic [31:0]        r_fifo_data [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] r_outst;
    logic [c_CNT_W-1:0] r_discard;
    logic [31:0]        r_fetch_pc;
    logic [31:0]        r_resp_pc;

    logic [c_SUM_W-1:0] w_credit_used;
    logic               w_issue;
    logic               w_resp_take;
    logic               w_resp_drop;
    logic               w_fifo_valid;
    logic               w_pop;
    logic               w_push;
    logic               w_bypass;
    logic [31:0]        w_redirect_pc;

    // Every request reserves a slot until its response is pushed, dropped or
    // consumed, so the FIFO can never overflow.
    assign w_credit_used = c_SUM_W'(r_count) + c_SUM_W'(r_outst) + c_SUM_W'(r_discard);
    assign IMemReq       = Reset & ~Redirect & (w_credit_used < c_DEPTH_S);
    assign IMemAddr      = r_fetch_pc;
    assign w_issue       = IMemReq & IMemGnt;

    // Stale responses (from before a redirect) are counted off by r_discard;
    // a response in the redirect cycle itself is stale too.
    assign w_resp_take   = Reset & IMemRValid & ~Redirect & (r_discard == '0);
    assign w_resp_drop   = IMemRValid & (r_discard != '0);

    assign w_fifo_valid  = (r_count != '0);
    assign w_pop         = Take & w_fifo_valid & ~Redirect;
    assign w_redirect_pc = RedirectPC & c_ALIGN;

`ifdef PREFETCH_BYPASS_EN
    // Response into an empty queue is shown directly; if taken in the same
    // cycle it never enters the FIFO.
    assign w_bypass = w_resp_take & (r_count == '0);
    assign w_push   = w_resp_take & ~(w_bypass & Take);
`else
    assign w_bypass = 1'b0;
    assign w_push   = w_resp_take;
`endif

    always_comb begin
        InstrValid = 1'b0;
        Instr      = '0;
        InstrPC    = '0;
        if (w_fifo_valid) begin
            InstrValid = 1'b1;
            Instr      = r_fifo_data[r_rd_ptr];
            InstrPC    = r_fifo_pc[r_rd_ptr];
        end else if (w_bypass) begin
            InstrValid = 1'b1;
            Instr      = IMemRData;
            InstrPC    = r_resp_pc;
        end
    end

    // Queue storage needs no reset: entries are only visible through r_count.
    always_ff @(posedge CLK) begin
        if (Reset && w_push) begin
            r_fifo_pc[r_wr_ptr]   <= r_resp_pc;
            r_fifo_data[r_wr_ptr] <= IMemRData;
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_outst    <= '0;
            r_discard  <= '0;
            r_fetch_pc <= RESET_PC & c_ALIGN;
            r_resp_pc  <= RESET_PC & c_ALIGN;
        end else if (Redirect) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_outst    <= '0;
            // Everything still in flight becomes stale, less any response
            // arriving (and dropped) right now.
            r_discard  <= r_discard + r_outst - c_CNT_W'(IMemRValid);
            r_fetch_pc <= w_redirect_pc;
            r_resp_pc  <= w_redirect_pc;
        end else begin
            if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_resp_take) begin
                r_resp_pc <= r_resp_pc + 32'd4;
            end
            if (w_resp_drop) begin
                r_discard <= r_discard - 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_outst <= r_outst + c_CNT_W'(w_issue) - c_CNT_W'(w_resp_take);
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch_queue.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : tb_instr_prefetch_queue                                     |
// | Description : Directed self-checking bench for instr_prefetch_queue. A    |
// |               second instance with RESET_PC=FFFF_FFF8 shares stimulus     |
// |               and response timing to cover address wrap-around.           |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module tb_instr_prefetch_queue;

    localparam logic [31:0] c_KEY = 32'hA5A5_0000;
    localparam logic [31:0] c_PC2 = 32'hFFFF_FFF8;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        IMemGnt = 1'b1;
    logic        IMemRValid = 1'b0;
    logic [31:0] IMemRData = '0;
    logic [31:0] IMemRData2 = '0;
    logic        Take = 1'b0;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectPC = '0;

    logic        IMemReq, IMemReq2;
    logic [31:0] IMemAddr, IMemAddr2;
    logic [31:0] Instr, Instr2, InstrPC, InstrPC2;
    logic        InstrValid, InstrValid2;

    int vectors     = 0;
    int miscompares = 0;
    int mem_lat     = 1;
    int mem_cyc     = 0;

    typedef struct {
        logic [31:0] a1;
        logic [31:0] a2;
        int          due;
    } mreq_t;
    mreq_t mq[$];

    instr_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .CLK(CLK), .Reset(Reset),
        .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemGnt(IMemGnt),
        .IMemRValid(IMemRValid), .IMemRData(IMemRData),
        .Instr(Instr), .InstrPC(InstrPC), .InstrValid(InstrValid),
        .Take(Take), .Redirect(Redirect), .RedirectPC(RedirectPC)
    );

    instr_prefetch_queue #(.DEPTH(4), .RESET_PC(c_PC2)) dut2 (
        .CLK(CLK), .Reset(Reset),
        .IMemReq(IMemReq2), .IMemAddr(IMemAddr2), .IMemGnt(IMemGnt),
        .IMemRValid(IMemRValid), .IMemRData(IMemRData2),
        .Instr(Instr2), .InstrPC(InstrPC2), .InstrValid(InstrValid2),
        .Take(Take), .Redirect(Redirect), .RedirectPC(RedirectPC)
    );

    always #5 CLK = ~CLK;

    // Memory with fixed latency mem_lat; returns addr ^ c_KEY in order.
    // Both instances issue in lock-step, so one queue serves both.
    always begin : p_mem
        logic        req_s, rst_s;
        logic [31:0] a1_s, a2_s;
        @(negedge CLK);
        req_s = IMemReq & IMemGnt;
        rst_s = Reset;
        a1_s  = IMemAddr;
        a2_s  = IMemAddr2;
        @(posedge CLK);
        #1;
        mem_cyc++;
        if (!rst_s) mq.delete();
        else if (req_s) mq.push_back('{a1_s, a2_s, mem_cyc + mem_lat - 1});
        if (rst_s && mq.size() > 0 && mq[0].due <= mem_cyc) begin
            IMemRValid = 1'b1;
            IMemRData  = mq[0].a1 ^ c_KEY;
            IMemRData2 = mq[0].a2 ^ c_KEY;
            void'(mq.pop_front());
        end else begin
            IMemRValid = 1'b0;
            IMemRData  = '0;
            IMemRData2 = '0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; queue occupancy may never
    // exceed DEPTH.
    task automatic adv();
        @(posedge CLK);
        #1;
        chk("occupancy_bound", {31'd0, (dut.r_count <= 3'd4)}, 32'd1);
    endtask

    task automatic do_reset(input int lat, input logic take);
        Reset    = 1'b0;
        Redirect = 1'b0;
        Take     = take;
        adv();
        mem_lat = lat;
        #3;
        chk("rst_req",    {31'd0, IMemReq},    32'd0);
        chk("rst_addr",   IMemAddr,            32'd0);
        chk("rst_addr2",  IMemAddr2,           c_PC2);
        chk("rst_valid",  {31'd0, InstrValid}, 32'd0);
        chk("rst_instr",  Instr,               32'd0);
        chk("rst_pc",     InstrPC,             32'd0);
        adv();
        Reset = 1'b1;
    endtask

    initial begin : p_main
        int          nreq;
        logic [31:0] e2;
        logic [31:0] drain_pc [4];

        // ---- streaming with 1-cycle memory, Take held high ----
        do_reset(1, 1'b1);
        #3;
        chk("s_req0",   {31'd0, IMemReq},  32'd1);
        chk("s_addr0",  IMemAddr,          32'd0);
        chk("s_req2",   {31'd0, IMemReq2}, 32'd1);
        chk("s_addr2",  IMemAddr2,         c_PC2);
        chk("s_val0",   {31'd0, InstrValid}, 32'd0);
        adv();
        #3;
        chk("s_val1",   {31'd0, InstrValid}, 32'd0);
        chk("s_addr1",  IMemAddr,          32'd4);
        adv();
        for (int k = 0; k < 8; k++) begin
            #3;
            e2 = c_PC2 + 32'(4 * k);
            chk("s_valid",  {31'd0, InstrValid},  32'd1);
            chk("s_pc",     InstrPC,              32'(4 * k));
            chk("s_instr",  Instr,                32'(4 * k) ^ c_KEY);
            chk("w_valid",  {31'd0, InstrValid2}, 32'd1);
            chk("w_pc",     InstrPC2,             e2);
            chk("w_instr",  Instr2,               e2 ^ c_KEY);
            adv();
        end

        // ---- Take low: exactly DEPTH requests, then drain ----
        do_reset(1, 1'b0);
        nreq = 0;
        for (int c = 0; c < 10; c++) begin
            #3;
            if (IMemReq && IMemGnt) begin
                chk("f_addr", IMemAddr, 32'(4 * nreq));
                nreq++;
            end
            adv();
        end
        #3;
        chk("f_nreq",    32'(nreq),           32'd4);
        chk("f_req_off", {31'd0, IMemReq},    32'd0);
        chk("f_head",    InstrPC,             32'd0);
        Take = 1'b1;
        adv();
        #3;
        chk("d_pc1",     InstrPC,             32'h4);
        chk("d_req",     {31'd0, IMemReq},    32'd1);
        chk("d_addr",    IMemAddr,            32'h10);
        adv();
        drain_pc = '{32'h8, 32'hC, 32'h10, 32'h14};
        for (int k = 0; k < 4; k++) begin
            #3;
            chk("d_valid", {31'd0, InstrValid}, 32'd1);
            chk("d_pc",    InstrPC,             drain_pc[k]);
            adv();
        end

        // ---- reset mid-stream with three entries queued ----
        do_reset(1, 1'b0);
        for (int c = 0; c < 4; c++) adv();
        #3;
        chk("m_valid",   {31'd0, InstrValid}, 32'd1);
        chk("m_pc",      InstrPC,             32'd0);
        chk("m_req_off", {31'd0, IMemReq},    32'd0);
        do_reset(1, 1'b1);
        #3;
        chk("m_restart_req",  {31'd0, IMemReq}, 32'd1);
        chk("m_restart_addr", IMemAddr,         32'd0);
        adv();
        adv();
        #3;
        chk("m_first_pc",     InstrPC,          32'd0);

        // ---- 3-cycle memory, redirect with two requests in flight ----
        do_reset(3, 1'b1);
        adv();
        adv();
        Redirect   = 1'b1;
        RedirectPC = 32'h0000_0100;
        #3;
        chk("r_req_blocked", {31'd0, IMemReq}, 32'd0);
        adv();
        Redirect = 1'b0;
        #3;
        chk("r_req_new",  {31'd0, IMemReq},    32'd1);
        chk("r_addr_new", IMemAddr,            32'h100);
        chk("r_v5",       {31'd0, InstrValid}, 32'd0);
        adv();
        #3;
        chk("r_addr_nxt", IMemAddr,            32'h104);
        chk("r_v6",       {31'd0, InstrValid}, 32'd0);
        adv();
        #3;
        chk("r_v7",       {31'd0, InstrValid}, 32'd0);
        adv();
        #3;
        chk("r_v8",       {31'd0, InstrValid}, 32'd0);
        adv();
        for (int k = 0; k < 3; k++) begin
            #3;
            chk("r_valid", {31'd0, InstrValid}, 32'd1);
            chk("r_pc",    InstrPC,             32'h100 + 32'(4 * k));
            chk("r_instr", Instr,               (32'h100 + 32'(4 * k)) ^ c_KEY);
            adv();
        end

        // ---- redirect coinciding with the only outstanding response ----
        do_reset(1, 1'b1);
        adv();
        Redirect   = 1'b1;
        RedirectPC = 32'h0000_0103;
        #3;
        chk("c_req_blocked", {31'd0, IMemReq}, 32'd0);
        adv();
        Redirect = 1'b0;
        #3;
        chk("c_req",   {31'd0, IMemReq},    32'd1);
        chk("c_addr",  IMemAddr,            32'h100);
        chk("c_v4",    {31'd0, InstrValid}, 32'd0);
        adv();
        #3;
        chk("c_v5",    {31'd0, InstrValid}, 32'd0);
        adv();
        #3;
        chk("c_valid", {31'd0, InstrValid}, 32'd1);
        chk("c_pc",    InstrPC,             32'h100);
        chk("c_instr", Instr,               32'hA5A5_0100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
